// File: rtl/shreg_mode_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : shreg_mode_seq_if
// Brief    : Control/data bundle between the sequencer and its environment.
// Revision : 1.0 - initial release
// ============================================================================
interface shreg_mode_seq_if;
    logic       START;
    logic       ABORT;
    logic [3:0] PAT;
    logic [3:0] NSTEP;
    logic       DIR_FIRST;
    logic       FILL;
    logic       LOOP;
    logic [1:0] S;
    logic [3:0] D;
    logic       DSR;
    logic       DSL;
    logic       BUSY;
    logic       DONE;

    modport master (
        output START, ABORT, PAT, NSTEP, DIR_FIRST, FILL, LOOP,
        input  S, D, DSR, DSL, BUSY, DONE
    );

    modport slave (
        input  START, ABORT, PAT, NSTEP, DIR_FIRST, FILL, LOOP,
        output S, D, DSR, DSL, BUSY, DONE
    );
endinterface
`default_nettype wire

// File: rtl/shreg_mode_seq.sv
`default_nettype none
// ============================================================================
// Module   : shreg_mode_seq
// Brief    : Mode sequencer for a 4-bit universal shift register: one load,
//            then NSTEP shifts each way, one operation per DIV clock cycles.
//            Optional repeat mode enabled by defining SHREG_SEQ_LOOP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module shreg_mode_seq #(
    parameter int DIV   = 10,
    parameter int DIV_W = 4
) (
    input  logic             CP,
    input  logic             MR,
    shreg_mode_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PH1  = 3'd2,
        ST_PH2  = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    localparam logic [DIV_W-1:0] C_TICK = DIV_W'(DIV - 1);
    localparam logic [1:0]       C_HOLD = 2'b00;
    localparam logic [1:0]       C_SHR  = 2'b01;
    localparam logic [1:0]       C_SHL  = 2'b10;
    localparam logic [1:0]       C_LOAD = 2'b11;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [DIV_W-1:0] r_presc;
    logic [DIV_W-1:0] w_presc_nxt;
    logic [3:0]       r_step;
    logic [3:0]       w_step_nxt;
    logic [3:0]       r_nstep;
    logic [3:0]       r_pat;
    logic             r_dir;
    logic             r_fill;
    logic [1:0]       r_s;
    logic [1:0]       w_s_nxt;
    logic             r_busy;
    logic             w_busy_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_capture;
    logic             w_tick;
    logic             w_last_step;
    logic             w_phase_left;
    logic             w_loop;

    assign w_tick       = (r_presc == C_TICK);
    assign w_last_step  = (r_step == (r_nstep - 4'd1));
    // Left-shift phase is PH2 normally, PH1 when DIR_FIRST selects left first
    assign w_phase_left = (r_state == ST_PH2) ^ r_dir;

`ifdef SHREG_SEQ_LOOP_EN
    assign w_loop = bus.LOOP;
`else
    logic w_loop_unused;
    assign w_loop_unused = bus.LOOP;
    assign w_loop        = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_s_nxt     = C_HOLD;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_step_nxt  = r_step;
        w_capture   = 1'b0;
        if (r_state == ST_IDLE || w_tick) begin
            w_presc_nxt = '0;
        end else begin
            w_presc_nxt = r_presc + DIV_W'(1);
        end

        if (bus.ABORT) begin
            w_state_nxt = ST_IDLE;
            w_busy_nxt  = 1'b0;
            w_presc_nxt = '0;
            w_step_nxt  = 4'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.START) begin
                        w_capture   = 1'b1;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (w_tick) begin
                        w_s_nxt     = C_LOAD;
                        w_state_nxt = ST_PH1;
                    end
                end
                ST_PH1, ST_PH2: begin
                    if (w_tick) begin
                        if (r_nstep == 4'd0 || w_last_step) begin
                            w_step_nxt  = 4'd0;
                            w_state_nxt = (r_state == ST_PH1) ? ST_PH2 : ST_FIN;
                        end else begin
                            w_step_nxt = r_step + 4'd1;
                        end
                        if (r_nstep != 4'd0) begin
                            w_s_nxt = w_phase_left ? C_SHL : C_SHR;
                        end
                    end
                end
                ST_FIN: begin
                    if (w_loop) begin
                        w_state_nxt = ST_PH1;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_presc_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                    w_presc_nxt = '0;
                    w_step_nxt  = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge CP) begin
        if (MR) begin
            r_state <= ST_IDLE;
            r_presc <= '0;
            r_step  <= 4'd0;
            r_nstep <= 4'd0;
            r_pat   <= 4'd0;
            r_dir   <= 1'b0;
            r_fill  <= 1'b0;
            r_s     <= C_HOLD;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_presc <= w_presc_nxt;
            r_step  <= w_step_nxt;
            r_s     <= w_s_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            if (w_capture) begin
                r_pat   <= bus.PAT;
                r_nstep <= bus.NSTEP;
                r_dir   <= bus.DIR_FIRST;
                r_fill  <= bus.FILL;
            end
        end
    end

    assign bus.S    = r_s;
    assign bus.D    = r_pat;
    assign bus.DSR  = r_fill;
    assign bus.DSL  = r_fill;
    assign bus.BUSY = r_busy;
    assign bus.DONE = r_done;

endmodule
`default_nettype wire

// File: tb/tb_shreg_mode_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_shreg_mode_seq
// Brief    : Drives two sequencers (DIV=1 and DIV=4) with shared stimulus and
//            compares them against a timeline model of each run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shreg_mode_seq;

    logic       CP = 1'b0;
    logic       mr;
    logic       start;
    logic       abort;
    logic [3:0] pat;
    logic [3:0] nstep;
    logic       dir_first;
    logic       fill;
    logic       loop_req;

    int n_checks = 0;
    int n_errors = 0;

    always #5 CP = ~CP;

    shreg_mode_seq_if bus0 ();
    shreg_mode_seq_if bus1 ();

    assign bus0.START = start;   assign bus1.START = start;
    assign bus0.ABORT = abort;   assign bus1.ABORT = abort;
    assign bus0.PAT = pat;       assign bus1.PAT = pat;
    assign bus0.NSTEP = nstep;   assign bus1.NSTEP = nstep;
    assign bus0.DIR_FIRST = dir_first;
    assign bus1.DIR_FIRST = dir_first;
    assign bus0.FILL = fill;     assign bus1.FILL = fill;
    assign bus0.LOOP = loop_req; assign bus1.LOOP = loop_req;

    shreg_mode_seq #(.DIV(1), .DIV_W(1)) u_dut_div1 (.CP(CP), .MR(mr), .bus(bus0));
    shreg_mode_seq #(.DIV(4), .DIV_W(3)) u_dut_div4 (.CP(CP), .MR(mr), .bus(bus1));

    // Model: cycle k after the accepting edge; operation slot j sits at k = DIV*j.
    int         div_of [2] = '{1, 4};
    int         m_k    [2];
    logic       m_busy [2];
    logic       m_done [2];
    logic [1:0] m_s    [2];
    logic [3:0] m_d    [2];
    logic [3:0] m_n    [2];
    logic       m_fill [2];
    logic       m_dir  [2];

    function automatic logic [1:0] exp_op(input int div, input int kk,
                                          input logic [3:0] n, input logic dir);
        int j;
        j = kk / div;
        if (kk % div != 0) return 2'b00;
        if (j == 1) return 2'b11;
        if (n == 4'd0) return 2'b00;
        if (j <= int'(n) + 1) return dir ? 2'b10 : 2'b01;
        return dir ? 2'b01 : 2'b10;
    endfunction

    task automatic model_step(input int i);
        int slots;
        m_done[i] = 1'b0;
        if (mr) begin
            m_busy[i] = 1'b0; m_s[i] = 2'b00; m_d[i] = 4'd0;
            m_fill[i] = 1'b0; m_k[i] = 0;
        end else if (m_busy[i]) begin
            if (abort) begin
                m_busy[i] = 1'b0; m_s[i] = 2'b00; m_k[i] = 0;
            end else begin
                m_k[i] = m_k[i] + 1;
                slots  = (m_n[i] == 4'd0) ? 3 : 1 + 2 * int'(m_n[i]);
                if (m_k[i] == div_of[i] * slots + 1) begin
                    m_s[i] = 2'b00;
`ifdef SHREG_SEQ_LOOP_EN
                    if (loop_req) begin
                        m_k[i] = (div_of[i] == 1) ? 1 : div_of[i] + 1;
                    end else begin
                        m_busy[i] = 1'b0; m_done[i] = 1'b1;
                    end
`else
                    m_busy[i] = 1'b0; m_done[i] = 1'b1;
`endif
                end else begin
                    m_s[i] = exp_op(div_of[i], m_k[i], m_n[i], m_dir[i]);
                end
            end
        end else begin
            m_s[i] = 2'b00;
            if (start && !abort) begin
                m_busy[i] = 1'b1; m_k[i] = 0;
                m_d[i] = pat; m_n[i] = nstep; m_dir[i] = dir_first; m_fill[i] = fill;
            end
        end
    endtask

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic compare_all();
        check_eq("div1.S",    8'(bus0.S),               8'(m_s[0]));
        check_eq("div1.D",    8'(bus0.D),               8'(m_d[0]));
        check_eq("div1.DSRL", 8'({bus0.DSR, bus0.DSL}), 8'({m_fill[0], m_fill[0]}));
        check_eq("div1.BUSY", 8'(bus0.BUSY),            8'(m_busy[0]));
        check_eq("div1.DONE", 8'(bus0.DONE),            8'(m_done[0]));
        check_eq("div4.S",    8'(bus1.S),               8'(m_s[1]));
        check_eq("div4.D",    8'(bus1.D),               8'(m_d[1]));
        check_eq("div4.DSRL", 8'({bus1.DSR, bus1.DSL}), 8'({m_fill[1], m_fill[1]}));
        check_eq("div4.BUSY", 8'(bus1.BUSY),            8'(m_busy[1]));
        check_eq("div4.DONE", 8'(bus1.DONE),            8'(m_done[1]));
    endtask

    task automatic cycle();
        @(posedge CP);
        model_step(0);
        model_step(1);
        #1;
        compare_all();
    endtask

    initial begin
        mr = 1'b1; start = 1'b1; abort = 1'b0; pat = 4'hF; nstep = 4'd1;
        dir_first = 1'b0; fill = 1'b1; loop_req = 1'b0;
        repeat (3) cycle();
        mr = 1'b0; start = 1'b0;
        cycle();

        pat = 4'b1001; nstep = 4'd2; dir_first = 1'b0; fill = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (30) cycle();

        nstep = 4'd0; pat = 4'b0110; fill = 1'b1; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (20) cycle();

        pat = 4'b0101; nstep = 4'd3; dir_first = 1'b1; start = 1'b1;
        repeat (60) cycle();
        start = 1'b0;
        repeat (5) cycle();

        pat = 4'b0011; nstep = 4'd4; dir_first = 1'b0; start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (6) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        repeat (3) cycle();
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (30) cycle();

        repeat (6000) begin
            mr        = ($urandom_range(0, 299) == 0);
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 149) == 0);
            pat       = 4'($urandom);
            nstep     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            dir_first = 1'($urandom);
            fill      = 1'($urandom);
            loop_req  = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
